// File: rtl/apb_decoder_wdt.sv
// APB address decoder / response mux with a per-access wait-state watchdog.
// Unmapped addresses and stalled completers terminate with PSLVERR.
module apb_decoder_wdt #(
    parameter int                         NUM_SLAVES      = 2,
    parameter logic [NUM_SLAVES*32-1:0]   START_ADDRS     = {32'h8c000800, 32'h8c000000},
    parameter logic [NUM_SLAVES*32-1:0]   END_ADDRS       = {32'h8c000fff, 32'h8c000598},
    parameter int                         MAX_WAIT_STATES = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [31:0]                  PADDR,
    input  logic [31:0]                  PWDATA,
    output logic [31:0]                  PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_SLAVES-1:0]        PSEL_S,
    output logic                         PENABLE_S,
    output logic                         PWRITE_S,
    output logic [31:0]                  PADDR_S,
    output logic [31:0]                  PWDATA_S,
    input  logic [NUM_SLAVES*32-1:0]     PRDATA_S,
    input  logic [NUM_SLAVES-1:0]        PREADY_S,
    input  logic [NUM_SLAVES-1:0]        PSLVERR_S,
    output logic                         timeout_out,
    output logic                         decerr_out,
    output logic [31:0]                  err_addr_out,
    output logic [7:0]                   err_count_out
);

    localparam int         SW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [7:0] MAXW = 8'(MAX_WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        UNMAPPED
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   sel_q;
    logic [SW-1:0]   sel_nx;
    logic [7:0]      wait_cnt;
    logic [7:0]      wait_nx;

    logic            setup;
    logic            hit_any;
    logic [SW-1:0]   hit_idx;

    logic            slv_ready;
    logic            slv_err;
    logic [31:0]     slv_rdata;

    logic [NUM_SLAVES-1:0] psel_c;
    logic            penable_c;
    logic [31:0]     prdata_c;
    logic            pready_c;
    logic            pslverr_c;
    logic            abort;
    logic            dec_done;

    assign setup = PSEL & ~PENABLE;

    // Scan from the top so the lowest matching window wins on overlap.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (PADDR >= START_ADDRS[i*32 +: 32] &&
                PADDR <= END_ADDRS[i*32 +: 32]) begin
                hit_any = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SW'(i)) begin
                slv_ready = PREADY_S[i];
                slv_err   = PSLVERR_S[i];
                slv_rdata = PRDATA_S[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            sel_q    <= sel_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sel_nx    = sel_q;
        wait_nx   = wait_cnt;
        psel_c    = '0;
        penable_c = 1'b0;
        prdata_c  = '0;
        pready_c  = 1'b0;
        pslverr_c = 1'b0;
        abort     = 1'b0;
        dec_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    sel_nx   = hit_idx;
                    wait_nx  = '0;
                    state_nx = hit_any ? ACCESS : UNMAPPED;
                    for (int i = 0; i < NUM_SLAVES; i++) begin
                        psel_c[i] = hit_any && (hit_idx == SW'(i));
                    end
                end
            end
            ACCESS: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    psel_c[i] = PSEL && (sel_q == SW'(i));
                end
                penable_c = PENABLE;
                prdata_c  = slv_rdata;
                if (!PSEL) begin
                    state_nx = IDLE;
                end else if (PENABLE) begin
                    if (slv_ready) begin
                        pready_c  = 1'b1;
                        pslverr_c = slv_err;
                        state_nx  = IDLE;
                    end else if (wait_cnt == MAXW) begin
                        // Completer stalled too long: terminate upstream.
                        pready_c  = 1'b1;
                        pslverr_c = 1'b1;
                        prdata_c  = '0;
                        abort     = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        wait_nx = wait_cnt + 8'd1;
                    end
                end
            end
            UNMAPPED: begin
                if (!PSEL) begin
                    state_nx = IDLE;
                end else if (PENABLE) begin
                    pready_c  = 1'b1;
                    pslverr_c = 1'b1;
                    dec_done  = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even mid-transfer.
    assign PSEL_S    = rst_n ? psel_c : '0;
    assign PENABLE_S = rst_n & penable_c;
    assign PWRITE_S  = rst_n & PWRITE;
    assign PADDR_S   = rst_n ? PADDR : '0;
    assign PWDATA_S  = rst_n ? PWDATA : '0;
    assign PRDATA    = rst_n ? prdata_c : '0;
    assign PREADY    = rst_n & pready_c;
    assign PSLVERR   = rst_n & pslverr_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_out   <= 1'b0;
            decerr_out    <= 1'b0;
            err_addr_out  <= '0;
            err_count_out <= '0;
        end else begin
            timeout_out <= abort;
            decerr_out  <= dec_done;
            if (abort || dec_done) begin
                err_addr_out <= PADDR;
                if (err_count_out != 8'hff) begin
                    err_count_out <= err_count_out + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_decoder_wdt.sv
// Directed bench for apb_decoder_wdt: vector table plus watchdog,
// saturation and reset sequences.
module tb_apb_decoder_wdt;

    localparam logic [31:0] A000  = 32'h8c000000;
    localparam logic [31:0] A10   = 32'h8c000010;
    localparam logic [31:0] A20   = 32'h8c000020;
    localparam logic [31:0] A598  = 32'h8c000598;
    localparam logic [31:0] A599  = 32'h8c000599;
    localparam logic [31:0] A700  = 32'h8c000700;
    localparam logic [31:0] A800  = 32'h8c000800;
    localparam logic [31:0] AFFF  = 32'h8c000fff;
    localparam logic [31:0] A1000 = 32'h8c001000;
    localparam logic [63:0] RD    = 64'h12345678_deadbeef;
    localparam logic [63:0] RD2   = 64'h55aa55aa_00000000;
    localparam logic [63:0] RDW   = 64'h00000000_cafef00d;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  psel_s;
    logic        penable_s;
    logic        pwrite_s;
    logic [31:0] paddr_s;
    logic [31:0] pwdata_s;
    logic [63:0] prdata_s;
    logic [1:0]  pready_s;
    logic [1:0]  pslverr_s;
    logic        timeout;
    logic        decerr;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int n_cmp;
    int n_bad;

    apb_decoder_wdt dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PSEL          (psel),
        .PENABLE       (penable),
        .PWRITE        (pwrite),
        .PADDR         (paddr),
        .PWDATA        (pwdata),
        .PRDATA        (prdata),
        .PREADY        (pready),
        .PSLVERR       (pslverr),
        .PSEL_S        (psel_s),
        .PENABLE_S     (penable_s),
        .PWRITE_S      (pwrite_s),
        .PADDR_S       (paddr_s),
        .PWDATA_S      (pwdata_s),
        .PRDATA_S      (prdata_s),
        .PREADY_S      (pready_s),
        .PSLVERR_S     (pslverr_s),
        .timeout_out   (timeout),
        .decerr_out    (decerr),
        .err_addr_out  (err_addr),
        .err_count_out (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        psel;
        logic        pen;
        logic        pw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  rdy_s;
        logic [1:0]  err_s;
        logic [63:0] rd_s;
        logic [78:0] exp;
    } vec_t;

    function automatic logic [78:0] pk(
        input logic [1:0] e_psel, input logic e_pen, input logic e_rdy,
        input logic e_err, input logic [31:0] e_rdata, input logic e_to,
        input logic e_de, input logic [31:0] e_addr, input logic [7:0] e_cnt);
        return {e_psel, e_pen, e_rdy, e_err, e_rdata, e_to, e_de, e_addr, e_cnt};
    endfunction

    function automatic logic [78:0] obs();
        return {psel_s, penable_s, pready, pslverr, prdata,
                timeout, decerr, err_addr, err_count};
    endfunction

    function automatic vec_t mk(
        input logic ps, input logic pe, input logic pw, input logic [31:0] a,
        input logic [31:0] wd, input logic [1:0] rs, input logic [1:0] es,
        input logic [63:0] rd, input logic [78:0] e);
        vec_t v;
        v.psel = ps; v.pen = pe; v.pw = pw; v.addr = a; v.wd = wd;
        v.rdy_s = rs; v.err_s = es; v.rd_s = rd; v.exp = e;
        return v;
    endfunction

    task automatic set_in(
        input logic ps, input logic pe, input logic pw, input logic [31:0] a,
        input logic [31:0] wd, input logic [1:0] rs, input logic [1:0] es,
        input logic [63:0] rd);
        psel = ps; penable = pe; pwrite = pw; paddr = a; pwdata = wd;
        pready_s = rs; pslverr_s = es; prdata_s = rd;
    endtask

    task automatic chk(input string nm, input logic [78:0] e);
        logic [78:0] a;
        a = obs();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic chk_bc(input string nm, input logic [64:0] e);
        logic [64:0] a;
        a = {paddr_s, pwdata_s, pwrite_s};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[21];

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Row order: write w/ waits, read, unmapped, boundaries, slave err, PSEL drop.
        vecs[0]  = mk(1,0,1,A10,32'ha5a50001,2'b00,2'b00,64'h0, pk(2'b01,0,0,0,0,0,0,0,0));
        vecs[1]  = mk(1,1,1,A10,32'ha5a50001,2'b00,2'b00,64'h0, pk(2'b01,1,0,0,0,0,0,0,0));
        vecs[2]  = mk(1,1,1,A10,32'ha5a50001,2'b00,2'b00,64'h0, pk(2'b01,1,0,0,0,0,0,0,0));
        vecs[3]  = mk(1,1,1,A10,32'ha5a50001,2'b01,2'b00,64'h0, pk(2'b01,1,1,0,0,0,0,0,0));
        vecs[4]  = mk(0,0,0,0,0,2'b00,2'b00,64'h0,             pk(2'b00,0,0,0,0,0,0,0,0));
        vecs[5]  = mk(1,0,0,A800,0,2'b00,2'b00,RD,             pk(2'b10,0,0,0,0,0,0,0,0));
        vecs[6]  = mk(1,1,0,A800,0,2'b10,2'b00,RD,             pk(2'b10,1,1,0,32'h12345678,0,0,0,0));
        vecs[7]  = mk(1,0,0,A700,0,2'b00,2'b00,RD,             pk(2'b00,0,0,0,0,0,0,0,0));
        vecs[8]  = mk(1,1,0,A700,0,2'b11,2'b00,RD,             pk(2'b00,0,1,1,0,0,0,0,0));
        vecs[9]  = mk(0,0,0,0,0,2'b00,2'b00,64'h0,             pk(2'b00,0,0,0,0,0,1,A700,1));
        vecs[10] = mk(1,0,0,A598,0,2'b00,2'b00,64'h0,          pk(2'b01,0,0,0,0,0,0,A700,1));
        vecs[11] = mk(1,1,0,A598,0,2'b01,2'b00,64'h0,          pk(2'b01,1,1,0,0,0,0,A700,1));
        vecs[12] = mk(1,0,0,A599,0,2'b00,2'b00,64'h0,          pk(2'b00,0,0,0,0,0,0,A700,1));
        vecs[13] = mk(1,1,0,A599,0,2'b00,2'b00,64'h0,          pk(2'b00,0,1,1,0,0,0,A700,1));
        vecs[14] = mk(1,0,0,AFFF,0,2'b00,2'b00,RD2,            pk(2'b10,0,0,0,0,0,1,A599,2));
        vecs[15] = mk(1,1,0,AFFF,0,2'b10,2'b10,RD2,            pk(2'b10,1,1,1,32'h55aa55aa,0,0,A599,2));
        vecs[16] = mk(1,0,1,A000,0,2'b00,2'b00,64'h0,          pk(2'b01,0,0,0,0,0,0,A599,2));
        vecs[17] = mk(0,0,0,0,0,2'b00,2'b00,64'h0,             pk(2'b00,0,0,0,0,0,0,A599,2));
        vecs[18] = mk(1,0,0,A1000,0,2'b00,2'b00,64'h0,         pk(2'b00,0,0,0,0,0,0,A599,2));
        vecs[19] = mk(0,0,0,0,0,2'b00,2'b00,64'h0,             pk(2'b00,0,0,0,0,0,0,A599,2));
        vecs[20] = mk(0,0,0,0,0,2'b00,2'b00,64'h0,             pk(2'b00,0,0,0,0,0,0,A599,2));

        rst_n = 1'b0;
        set_in(1,0,1,A10,32'h11112222,2'b11,2'b11,RD);
        repeat (2) @(negedge clk);
        chk("reset_state", pk(0,0,0,0,0,0,0,0,0));
        chk_bc("reset_bcast", 65'h0);
        step();
        rst_n = 1'b1;
        set_in(0,0,0,0,0,2'b00,2'b00,64'h0);
        step();

        for (int i = 0; i < 21; i++) begin
            set_in(vecs[i].psel, vecs[i].pen, vecs[i].pw, vecs[i].addr,
                   vecs[i].wd, vecs[i].rdy_s, vecs[i].err_s, vecs[i].rd_s);
            @(negedge clk);
            chk($sformatf("vec%0d", i), vecs[i].exp);
            chk_bc($sformatf("vec%0d_bcast", i), {vecs[i].addr, vecs[i].wd, vecs[i].pw});
            step();
        end

        // Slave 0 never ready: abort on access cycle 33.
        set_in(1,0,0,A10,0,2'b00,2'b00,RDW);
        @(negedge clk);
        chk("wdt_setup", pk(2'b01,0,0,0,0,0,0,A599,2));
        step();
        for (int k = 1; k <= 32; k++) begin
            set_in(1,1,0,A10,0,2'b00,2'b00,RDW);
            @(negedge clk);
            chk($sformatf("wdt_wait%0d", k), pk(2'b01,1,0,0,32'hcafef00d,0,0,A599,2));
            step();
        end
        @(negedge clk);
        chk("wdt_abort", pk(2'b01,1,1,1,0,0,0,A599,2));
        step();
        @(negedge clk);
        chk("wdt_after", pk(2'b00,0,0,0,0,1,0,A10,3));
        step();
        set_in(0,0,0,0,0,2'b00,2'b00,64'h0);
        @(negedge clk);
        chk("wdt_pulse_end", pk(2'b00,0,0,0,0,0,0,A10,3));
        step();

        // Slave ready exactly on access cycle 33 wins over the watchdog.
        set_in(1,0,1,A20,0,2'b00,2'b00,RDW);
        step();
        for (int k = 1; k <= 32; k++) begin
            set_in(1,1,1,A20,0,2'b00,2'b00,RDW);
            step();
        end
        set_in(1,1,1,A20,0,2'b01,2'b00,RDW);
        @(negedge clk);
        chk("late_ready", pk(2'b01,1,1,0,32'hcafef00d,0,0,A10,3));
        step();
        set_in(0,0,0,0,0,2'b00,2'b00,64'h0);
        @(negedge clk);
        chk("late_ready_after", pk(2'b00,0,0,0,0,0,0,A10,3));
        step();

        // 256 back-to-back unmapped accesses: count saturates at 255.
        for (int n = 0; n < 256; n++) begin
            logic [31:0] ea;
            logic [7:0]  ec;
            ea = (n == 0) ? A10 : (A700 + 32'(n - 1));
            ec = (3 + n > 255) ? 8'd255 : 8'(3 + n);
            set_in(1,0,0,A700 + 32'(n),0,2'b00,2'b00,RD);
            @(negedge clk);
            chk($sformatf("sat_setup%0d", n), pk(2'b00,0,0,0,0,0,(n > 0),ea,ec));
            step();
            set_in(1,1,0,A700 + 32'(n),0,2'b00,2'b00,RD);
            @(negedge clk);
            chk($sformatf("sat_access%0d", n), pk(2'b00,0,1,1,0,0,0,ea,ec));
            step();
        end
        set_in(0,0,0,0,0,2'b00,2'b00,64'h0);
        @(negedge clk);
        chk("sat_final", pk(2'b00,0,0,0,0,0,1,32'h8c0007ff,8'd255));
        step();

        // Reset during a stalled slave-0 access.
        set_in(1,0,1,A10,32'h0badf00d,2'b00,2'b00,RDW);
        step();
        for (int k = 0; k < 3; k++) begin
            set_in(1,1,1,A10,32'h0badf00d,2'b00,2'b00,RDW);
            step();
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset", pk(0,0,0,0,0,0,0,0,0));
        chk_bc("midreset_bcast", 65'h0);
        step();
        set_in(0,0,0,0,0,2'b00,2'b00,64'h0);
        rst_n = 1'b1;
        step();
        set_in(1,0,0,A800,0,2'b00,2'b00,RD);
        @(negedge clk);
        chk("post_reset_setup", pk(2'b10,0,0,0,0,0,0,0,0));
        step();
        set_in(1,1,0,A800,0,2'b10,2'b00,RD);
        @(negedge clk);
        chk("post_reset_read", pk(2'b10,1,1,0,32'h12345678,0,0,0,0));
        step();
        set_in(0,0,0,0,0,2'b00,2'b00,64'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_decoder_wdt.md
# apb_decoder_wdt

Parametrised APB interconnect stage between the test-bench/CPU-side APB requester and up to NUM_SLAVES completers (the audioport DUT being slave 0). Decodes PADDR against per-slave address windows, fans out PSEL, multiplexes read data and responses back, returns a zero-wait error for unmapped addresses, and aborts any access stalled longer than MAX_WAIT_STATES with PSLVERR. Error events are latched in status outputs.

## Interface
- NUM_SLAVES, 2, number of downstream completers (1..8)
- START_ADDRS, {32'h8c000800, 32'h8c000000}, NUM_SLAVES*32 packed; slice i = first address of slave i (inclusive)
- END_ADDRS, {32'h8c000fff, 32'h8c000598}, NUM_SLAVES*32 packed; slice i = last address of slave i (inclusive)
- MAX_WAIT_STATES, 32, access cycles with PREADY low tolerated before abort (1..255)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- PSEL, PENABLE, PWRITE  in  1 each  upstream APB control
- PADDR, PWDATA  in  32 each  upstream address / write data
- PRDATA  out  32  upstream read data
- PREADY, PSLVERR  out  1 each  upstream response
- PSEL_S  out  NUM_SLAVES  one-hot downstream selects
- PENABLE_S, PWRITE_S  out  1 each  broadcast control
- PADDR_S, PWDATA_S  out  32 each  broadcast address / data (= PADDR, PWDATA)
- PRDATA_S  in  NUM_SLAVES*32  downstream read data, slice i from slave i
- PREADY_S, PSLVERR_S  in  NUM_SLAVES each  downstream responses
- timeout_out  out  1  one-cycle pulse on watchdog abort
- decerr_out  out  1  one-cycle pulse on unmapped-address completion
- err_addr_out  out  32  PADDR of most recent error (timeout or decerr)
- err_count_out  out  8  saturating count of errors (stops at 255)

## Operation
- hit[i] = START_i <= PADDR <= END_i; overlapping windows: lowest index wins. No hit = unmapped.
- FSM states: IDLE, ACCESS, UNMAPPED.
- IDLE: on PSEL=1 & PENABLE=0 (setup) latch sel_q = hit index, clear wait_cnt; -> ACCESS if mapped, -> UNMAPPED otherwise. PSEL_S[sel] asserted combinationally during setup.
- ACCESS: PSEL_S[sel_q]=PSEL, PENABLE_S=PENABLE; PRDATA/PREADY/PSLVERR = slice sel_q. PREADY_S[sel_q]=0 -> wait_cnt+1. PREADY_S=1 -> complete, -> IDLE.
- Watchdog: in ACCESS with wait_cnt == MAX_WAIT_STATES and PREADY_S still 0: upstream PREADY=1, PSLVERR=1, PRDATA=0, timeout_out pulses, -> IDLE; downstream PSEL_S/PENABLE_S low from next cycle. Slave PREADY=1 in that same cycle wins (normal completion, no timeout).
- UNMAPPED: no PSEL_S asserted; first access cycle (PENABLE=1) returns PREADY=1, PSLVERR=1, PRDATA=0, decerr_out pulse, -> IDLE.
- PSEL dropped by requester in ACCESS/UNMAPPED: -> IDLE, no error, no count.
- On any error: err_addr_out <= PADDR, err_count_out <= min(count+1,255).

## Timing
- Reset values: all outputs 0; state IDLE, sel_q 0, wait_cnt 0.
- PSEL_S/PENABLE_S/PWRITE_S/PADDR_S/PWDATA_S: combinational from upstream (zero latency); response mux combinational from sel_q.
- PREADY=0 in IDLE; PSLVERR only nonzero in completing cycle.
- Mapped access max duration: MAX_WAIT_STATES+1 access cycles; unmapped: exactly 1 access cycle.
- Back-to-back: completion cycle -> IDLE, so a setup phase in the very next cycle is accepted.
- Status outputs registered: err_addr_out/err_count_out update, timeout_out/decerr_out high, in the cycle after the completing cycle.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs 0; status cleared.

## Test plan
- Write 0xA5A5_0001 to 0x8c000010, slave 0 PREADY after 2 waits -> PSEL_S=01 only, 3 access cycles, PREADY=1 PSLVERR=0, no status change.
- Read 0x8c000800, slave 1 returns 0x1234_5678 at 0 waits -> PSEL_S=10, PRDATA=0x1234_5678, 2-cycle transfer.
- Access 0x8c000700 (gap) -> PSEL_S=00, PREADY=1 PSLVERR=1 PRDATA=0 first access cycle, decerr_out pulse, err_addr_out=0x8c000700, err_count_out=1.
- Slave 0 holds PREADY=0 forever -> upstream PREADY=PSLVERR=1 at access cycle 33, timeout_out pulse, PSEL_S=00 next cycle; slave PREADY=1 on cycle 33 instead -> normal completion.
- 256 unmapped accesses -> err_count_out saturates at 255; back-to-back transfers with no idle cycle all complete.
- rst_n low during a stalled slave-0 access -> all outputs 0 immediately; next transfer decodes normally.
